// File: rtl/lisa_qspi_arb.sv
// lisa_qspi_arb: shares one QSPI serializer between fetch (port 0) and data (port 1).
// Optional WAIT-state timeout with abort/err is built when LISA_QSPI_ARB_TIMEOUT_EN is defined.
module lisa_qspi_arb #(
  parameter int AW           = 24,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT_CYC  = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_ce_sel,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_ce_sel,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic          q_start,
  output logic          q_we,
  output logic          q_ce_sel,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_wdata,
  input  logic [DW-1:0] q_rdata,
  input  logic          q_done,
  output logic          q_abort,
  output logic [1:0]    gnt
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg;
  logic          err_reg;
  logic          grant0, grant1, capture, expire;

  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    capture    = 1'b0;
    q_start    = 1'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Data port wins ties until fetch has been passed over STARVE_LIMIT times.
        if (p0_req && (!p1_req || (STARVE_LIMIT != 0 && starve_reg == STARVE_MAX))) begin
          grant0     = 1'b1;
          state_next = ISSUE;
        end else if (p1_req) begin
          grant1     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        q_start    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (q_done) begin
          capture    = 1'b1;
          state_next = ACK;
        end else if (expire) begin
          state_next = ACK;
        end
      end
      ACK: begin
        p0_ack     = gnt[0];
        p1_ack     = gnt[1];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      gnt        <= 2'b00;
      q_we       <= 1'b0;
      q_ce_sel   <= 1'b0;
      q_addr     <= '0;
      q_wdata    <= '0;
      starve_reg <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant0 || grant1) begin
        gnt      <= {grant1, grant0};
        q_we     <= grant0 ? p0_we     : p1_we;
        q_ce_sel <= grant0 ? p0_ce_sel : p1_ce_sel;
        q_addr   <= grant0 ? p0_addr   : p1_addr;
        q_wdata  <= grant0 ? p0_wdata  : p1_wdata;
      end else if (state_reg == ACK) begin
        gnt <= 2'b00;
      end
      if (grant0) begin
        starve_reg <= '0;
      end else if (grant1 && p0_req && starve_reg != STARVE_MAX) begin
        starve_reg <= starve_reg + 1'b1;
      end
      // Writes complete without touching the requester's read data.
      if (capture && !q_we) begin
        if (gnt[0]) p0_rdata <= q_rdata;
        if (gnt[1]) p1_rdata <= q_rdata;
      end
    end
  end

`ifdef LISA_QSPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] wait_cnt_reg;

  // Counter sits at 0 outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                   wait_cnt_reg <= '0;
      if (state_reg == WAIT) err_reg <= expire && !q_done;
    end
  end

  assign expire  = (state_reg == WAIT) && (wait_cnt_reg == TO_LAST);
  assign q_abort = expire && !q_done;
`else
  assign expire  = 1'b0;
  assign q_abort = 1'b0;
  assign err_reg = 1'b0;
`endif

  assign p0_err = p0_ack & err_reg;
  assign p1_err = p1_ack & err_reg;

endmodule

// File: tb/tb_lisa_qspi_arb.sv
// Randomized bench for lisa_qspi_arb: drives both requesters and plays the serializer,
// predicting grants, acks and read data from a transaction-level model.
module tb_lisa_qspi_arb;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SL = 3;
`ifdef LISA_QSPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic p0_ack, p0_err, p1_ack, p1_err;
  logic q_start, q_we, q_ce_sel, q_abort;
  logic [AW-1:0] q_addr;
  logic [DW-1:0] q_wdata;
  logic [DW-1:0] q_rdata;
  logic q_done;
  logic [1:0] gnt;

  // Requester model state; the request pins follow it directly.
  logic          pend [2];
  logic          we_m [2];
  logic          ce_m [2];
  logic [AW-1:0] addr_m [2];
  logic [DW-1:0] wd_m [2];
  logic [DW-1:0] rd_m [2];
  int            starve_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lisa_qspi_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(pend[0]), .p0_we(we_m[0]), .p0_ce_sel(ce_m[0]), .p0_addr(addr_m[0]),
    .p0_wdata(wd_m[0]), .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(pend[1]), .p1_we(we_m[1]), .p1_ce_sel(ce_m[1]), .p1_addr(addr_m[1]),
    .p1_wdata(wd_m[1]), .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .q_start(q_start), .q_we(q_we), .q_ce_sel(q_ce_sel), .q_addr(q_addr),
    .q_wdata(q_wdata), .q_rdata(q_rdata), .q_done(q_done), .q_abort(q_abort), .gnt(gnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic raise(input int p, input logic we, input logic ce,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; we_m[p] = we; ce_m[p] = ce; addr_m[p] = a; wd_m[p] = d;
  endtask

  task automatic raise_rand(input int p);
    raise(p, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  // Called at the falling edge of an IDLE cycle with at least one request pending.
  // dly = cycles from q_start to the real q_done; early also pulses q_done in ISSUE.
  task automatic serve(input int dly, input logic early, input logic [DW-1:0] rd,
                       output logic [1:0] g_seen);
    int w;
    logic [1:0] g;
    if (pend[0] && pend[1]) w = (SL != 0 && starve_m == SL) ? 0 : 1;
    else                    w = pend[0] ? 0 : 1;
    if (w == 0) starve_m = 0;
    else if (pend[0] && starve_m < SL) starve_m++;
    g = (w == 0) ? 2'b01 : 2'b10;

    @(negedge clk);
    g_seen = gnt;
    check("issue_q_start", 32'(q_start), 32'd1);
    check("issue_gnt", 32'(gnt), 32'(g));
    check("q_we", 32'(q_we), 32'(we_m[w]));
    check("q_ce_sel", 32'(q_ce_sel), 32'(ce_m[w]));
    check("q_addr", 32'(q_addr), 32'(addr_m[w]));
    check("q_wdata", 32'(q_wdata), 32'(wd_m[w]));
    q_done = early;
    q_rdata = ~rd;
    repeat (dly - 1) begin
      @(negedge clk);
      q_done = 1'b0;
      check("wait_q_start", 32'(q_start), 32'd0);
      check("wait_gnt", 32'(gnt), 32'(g));
      check("wait_ack", 32'({p1_ack, p0_ack}), 32'd0);
      check("wait_abort", 32'(q_abort), 32'd0);
    end
    @(negedge clk);
    check("wait_gnt", 32'(gnt), 32'(g));
    check("wait_ack", 32'({p1_ack, p0_ack}), 32'd0);
    q_done = 1'b1;
    q_rdata = rd;

    @(negedge clk);
    q_done = 1'b0;
    q_rdata = DW'($urandom);
    if (!we_m[w]) rd_m[w] = rd;
    check("ack", 32'({p1_ack, p0_ack}), 32'(g));
    check("ack_err", 32'({p1_err, p0_err}), 32'd0);
    check("p0_rdata", 32'(p0_rdata), 32'(rd_m[0]));
    check("p1_rdata", 32'(p1_rdata), 32'(rd_m[1]));
    check("ack_gnt", 32'(gnt), 32'(g));
    $display("TXN port=%0d we=%0d ce=%0d addr=%06h wdata=%04h dly=%0d early=%0d rdata=%04h",
             w, we_m[w], ce_m[w], addr_m[w], wd_m[w], dly, early, rd);
    pend[w] = 1'b0;

    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_ack", 32'({p1_ack, p0_ack}), 32'd0);
  endtask

  initial begin
    logic [1:0] gs;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; we_m[p] = 1'b0; ce_m[p] = 1'b0;
      addr_m[p] = '0; wd_m[p] = '0; rd_m[p] = '0;
    end
    starve_m = 0;
    q_done = 1'b0;
    q_rdata = '0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_q_start", 32'(q_start), 32'd0);
    check("rst_q_addr", 32'(q_addr), 32'd0);
    check("rst_q_we", 32'(q_we), 32'd0);
    check("rst_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);
    check("rst_ack", 32'({p1_ack, p0_ack}), 32'd0);
    check("rst_abort", 32'(q_abort), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: fetch read, write on data port, early q_done ignored in ISSUE.
    raise(0, 1'b0, 1'b0, 24'h000100, 16'h0000);
    serve(8, 1'b0, 16'hA55A, gs);
    check("first_rdata", 32'(p0_rdata), 32'h0000A55A);
    raise(1, 1'b1, 1'b1, 24'h000020, 16'h1234);
    serve(3, 1'b0, 16'hBEEF, gs);
    raise(0, 1'b0, 1'b1, 24'h000040, 16'h0000);
    serve(4, 1'b1, 16'h5AA5, gs);

    // Both ports always requesting: three data grants, then one fetch grant.
    for (int k = 0; k < 8; k++) begin
      if (!pend[0]) raise(0, 1'b0, 1'b0, AW'($urandom), DW'($urandom));
      if (!pend[1]) raise_rand(1);
      serve(int'($urandom_range(1, 4)), 1'b0, DW'($urandom), gs);
      check("starve_order", 32'(gs), (k % 4 == 3) ? 32'd1 : 32'd2);
    end

    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) raise_rand(p);
      if (!pend[0] && !pend[1]) raise_rand(int'($urandom_range(0, 1)));
      serve(int'($urandom_range(1, 8)), 1'($urandom_range(0, 3) == 0), DW'($urandom), gs);
    end

    // Reset in the middle of a transfer.
    if (!pend[0]) raise_rand(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_q_addr", 32'(q_addr), 32'd0);
    check("midrst_q_start", 32'(q_start), 32'd0);
    check("midrst_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);
    check("midrst_ack", 32'({p1_ack, p0_ack}), 32'd0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    rd_m[0] = '0; rd_m[1] = '0;
    starve_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    raise(0, 1'b0, 1'b0, 24'h000200, 16'h0000);
    serve(5, 1'b0, 16'hC3C3, gs);

`ifdef LISA_QSPI_ARB_TIMEOUT_EN
    raise(1, 1'b0, 1'b1, 24'h000300, 16'h0000);
    @(negedge clk);
    check("to_q_start", 32'(q_start), 32'd1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check("to_abort", 32'(q_abort), (k == TO) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("to_ack", 32'({p1_ack, p0_ack}), 32'd2);
    check("to_err", 32'({p1_err, p0_err}), 32'd2);
    check("to_rdata", 32'(p1_rdata), 32'(rd_m[1]));
    $display("TXN port=1 timeout addr=000300");
    pend[1] = 1'b0;
    @(negedge clk);
    check("to_idle_gnt", 32'(gnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
